led_bank_arbiter: RTL and testbench

Round-robin arbiter that shares the 8-LED output bank between several pattern sources (free-running counter, status flags, debug patterns) running in the PLL clock domain. Each requester presents a request and its LED pattern; the arbiter grants exactly one owner at a time, enforces a minimum dwell so the pattern is visible, and preempts long holders when others wait. It sits between the pattern generators and the LED pins in the top level.

---
 rtl/led_bank_arbiter_pkg.sv | 21 ++
 rtl/led_bank_arbiter_rr_pick.sv | 28 ++
 rtl/led_bank_arbiter.sv | 131 +++++++++++++
 tb/tb_led_bank_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/led_bank_arbiter_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// The GAP state is only present when LED_BANK_ARB_BLANK_EN is defined.
package led_bank_arbiter_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MIN_HOLD = 16;
  localparam int DEF_MAX_HOLD = 1024;

`ifdef LED_BANK_ARB_BLANK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} arb_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD} arb_state_e;
`endif

  // LSB position of requester idx's pattern on the packed data bus.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the search starts one position
// after ptr_i and wraps, so the requester at ptr_i has the lowest priority.
module led_bank_arbiter_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         onehot_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);

  localparam int PW = $clog2(NREQ);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
        onehot_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
        idx_o   = PW'((int'(ptr_i) + k) % NREQ);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner arbitration for the LED bank with minimum dwell and
// preemption after MAX_HOLD. Define LED_BANK_ARB_BLANK_EN for a one-cycle blank on release.
//
// state | meaning
// IDLE  | no owner, LEDs dark, arbitrate every cycle
// HOLD  | one requester owns the bank, led_out follows its data
// GAP   | one blank cycle after a release, arbitrate (blanking build only)
module led_bank_arbiter
  import led_bank_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      led_out,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MIN_M1  = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  led_q, led_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_vld;
  logic [WIDTH-1:0]  owner_data;
  logic              release_c;

  led_bank_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_gnt),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );

  // ptr_q doubles as the current owner while in HOLD.
  assign owner_data = data[slice_lsb(32'(ptr_q), WIDTH) +: WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    led_d     = '0;
    release_c = 1'b0;
    case (state_q)
`ifdef LED_BANK_ARB_BLANK_EN
      ST_IDLE, ST_GAP: begin
`else
      ST_IDLE: begin
`endif
        cnt_d = '0;
        if (pick_vld) begin
          state_d = ST_HOLD;
          grant_d = pick_gnt;
          ptr_d   = pick_idx;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_HOLD: begin
        led_d = owner_data;
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        release_c = ((cnt_q >= MIN_M1) && !req[ptr_q]) ||
                    ((cnt_q >= MAX_M1) && |(req & ~grant_q));
        if (release_c) begin
`ifdef LED_BANK_ARB_BLANK_EN
          state_d = ST_GAP;
          grant_d = '0;
          led_d   = '0;
          cnt_d   = '0;
`else
          // Search starts after the old owner, so it rotates out naturally.
          if (pick_vld) begin
            grant_d = pick_gnt;
            ptr_d   = pick_idx;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            led_d   = '0;
            cnt_d   = '0;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      grant_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      led_q   <= led_d;
    end
  end

  assign grant   = grant_q;
  assign led_out = led_q;
  assign busy    = |grant_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: a driver feeds directed and random
// stimulus into an owner/hold-time reference model; a monitor compares each cycle.
module tb_led_bank_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MINH = 16;
  localparam int MAXH = 32;

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] l;
    logic         b;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   grant;
  logic [W-1:0]   led_out;
  logic           busy;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  int         m_own  = -1;
  int         m_held = 0;
  int         m_last = N - 1;
  logic [W-1:0] m_led = '0;

  always #5 clk = ~clk;

  led_bank_arbiter #(
    .NREQ(N), .WIDTH(W), .MIN_HOLD(MINH), .MAX_HOLD(MAXH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .grant   (grant),
    .led_out (led_out),
    .busy    (busy)
  );

  function automatic int rr(input logic [N-1:0] r, input int start);
    for (int k = 1; k <= N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] slice(input logic [N*W-1:0] d, input int i);
    return d[i*W +: W];
  endfunction

  // Predicts the outputs after the coming rising edge from the current inputs.
  task automatic model_step();
    int w;
    bit rel;
    bit others;
    exp_t e;
    if (!rst) begin
      m_own = -1; m_held = 0; m_last = N - 1; m_led = '0;
    end else if (m_own < 0) begin
      m_led = '0;
      w = rr(req, m_last);
      if (w >= 0) begin m_own = w; m_last = w; m_held = 1; end
    end else begin
      others = 1'b0;
      for (int i = 0; i < N; i++) if (i != m_own && req[i]) others = 1'b1;
      rel = (m_held >= MINH && !req[m_own]) || (m_held >= MAXH && others);
      if (!rel) begin
        m_led = slice(data, m_own);
        m_held++;
      end else begin
`ifdef LED_BANK_ARB_BLANK_EN
        m_own = -1; m_led = '0;
`else
        w = rr(req, m_own);
        if (w >= 0) begin
          m_led = slice(data, m_own);
          m_own = w; m_last = w; m_held = 1;
        end else begin
          m_own = -1; m_led = '0;
        end
`endif
      end
    end
    e.g = (m_own >= 0) ? (N'(1) << m_own) : '0;
    e.l = m_led;
    e.b = (m_own >= 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [N-1:0] q);
    @(negedge clk);
    rst  = r;
    req  = q;
    data = $urandom();
    model_step();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (grant !== e.g || led_out !== e.l || busy !== e.b) begin
        n_bad++;
        $display("FAIL %s t=%0t grant=%b want %b led_out=%h want %h busy=%b want %b",
                 phase, $time, grant, e.g, led_out, e.l, busy, e.b);
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    phase = "reset_req_all";
    repeat (3) step(1'b0, 4'b1111);
    phase = "first_grant";
    repeat (4) step(1'b1, 4'b1111);

    repeat (2) step(1'b0, 4'b0000);
    phase = "short_pulse";
    repeat (3) step(1'b1, 4'b0100);
    repeat (22) step(1'b1, 4'b0000);

    phase = "rotate";
    repeat (4 * MAXH * 2 + 10) step(1'b1, 4'b1111);

    repeat (2) step(1'b0, 4'b0000);
    phase = "sole_holder";
    repeat (2000) step(1'b1, 4'b0010);

    repeat (2) step(1'b0, 4'b0000);
    phase = "handover";
    repeat (3) step(1'b1, 4'b0001);
    repeat (3) step(1'b1, 4'b1001);
    repeat (30) step(1'b1, 4'b1000);
    repeat (5) step(1'b1, 4'b0000);

    repeat (2) step(1'b0, 4'b0000);
    phase = "mid_hold_reset";
    repeat (11) step(1'b1, 4'b0001);
    step(1'b0, 4'b0001);
    repeat (6) step(1'b1, 4'b0001);

    phase = "random";
    rq = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(5) == 0) rq[$urandom_range(N - 1)] ^= 1'b1;
      step(($urandom_range(499) == 0) ? 1'b0 : 1'b1, rq);
    end

    @(posedge clk);
    #2;
    phase = "drain";
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
